// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Byte-serial boot loader for the single-cycle MIPS core. Receives a framed
// program image on a valid/ready byte stream, assembles big-endian 32-bit
// words into instruction memory, and holds the core's PC clear until the
// whole image is written and its XOR checksum matches.
//
// Frame: LEN_HI, LEN_LO (N words), 4*N payload bytes MSB-first, CHK, where
// CHK is the XOR of all payload bytes.
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both 1. in_ready depends only on the state, never on
// in_valid, and the loader never stalls for memory writes.
//
// Ports
//   clk          system clock, rising edge
//   clr          asynchronous active-high reset
//   start        1-cycle pulse, starts a new frame from IDLE/DONE/ERR
//   in_valid     byte-stream valid
//   in_data      byte-stream data
//   in_ready     byte-stream ready (HDR0/HDR1/DATA/CHK)
//   imem_we      instruction-memory write strobe, one cycle per word
//   imem_addr    instruction-memory word address
//   imem_wdata   instruction word
//   cpu_clr      core PC clear, low only in DONE
//   done         image loaded and checksum good
//   err          load aborted
//   err_code     01 length > depth, 10 checksum mismatch, 11 timeout
//   words_loaded words written during the current frame
//   dbg_state    current FSM state, for checkers
// ---------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int AW      = 6,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_clr,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   words_loaded,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam int          TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0] DEPTH17 = 17'(1 << AW);

  state_t        state, state_nxt;
  logic [7:0]    len_hi;
  logic [AW:0]   n_words;
  logic [1:0]    byte_idx;
  logic [23:0]   word_sr;
  logic [7:0]    chk_acc;
  logic [TW-1:0] idle_cnt;
  logic [1:0]    err_code_nxt;

  logic          accept;
  logic          can_start;
  logic          timed_out;
  logic          last_byte_of_word;
  logic          last_word;
  logic [16:0]   n_hdr;

  assign accept            = in_ready & in_valid;
  assign can_start         = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign n_hdr             = {1'b0, len_hi, in_data};
  assign last_byte_of_word = (byte_idx == 2'd3);
  assign last_word         = ((words_loaded + 1'b1) == n_words);

  // The idle counter holds the number of idle cycles already elapsed, so the
  // TIMEOUT-th consecutive idle cycle is the one that finds it at TIMEOUT-1.
  assign timed_out = ((state == S_HDR1) || (state == S_DATA) || (state == S_CHK))
                     && !accept && (idle_cnt == IDLE_LAST);

  // Moore outputs straight from the state register.
  assign in_ready  = (state == S_HDR0) || (state == S_HDR1) ||
                     (state == S_DATA) || (state == S_CHK);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign cpu_clr   = (state != S_DONE);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    err_code_nxt = err_code;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt    = S_HDR0;
          err_code_nxt = 2'b00;
        end
      end
      S_HDR0: begin
        if (accept) state_nxt = S_HDR1;
      end
      S_HDR1: begin
        if (accept) begin
          if (n_hdr > DEPTH17) begin
            state_nxt    = S_ERR;
            err_code_nxt = 2'b01;
          end else if (n_hdr == 17'd0) begin
            state_nxt = S_CHK;
          end else begin
            state_nxt = S_DATA;
          end
        end else if (timed_out) begin
          state_nxt    = S_ERR;
          err_code_nxt = 2'b11;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (last_byte_of_word && last_word) state_nxt = S_CHK;
        end else if (timed_out) begin
          state_nxt    = S_ERR;
          err_code_nxt = 2'b11;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == chk_acc) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt    = S_ERR;
            err_code_nxt = 2'b10;
          end
        end else if (timed_out) begin
          state_nxt    = S_ERR;
          err_code_nxt = 2'b11;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: header capture, word assembly, checksum, memory write strobe.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      len_hi       <= 8'h00;
      n_words      <= '0;
      byte_idx     <= 2'd0;
      word_sr      <= 24'h0;
      chk_acc      <= 8'h00;
      idle_cnt     <= '0;
      err_code     <= 2'b00;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'h0;
      words_loaded <= '0;
    end else begin
      imem_we  <= 1'b0;
      err_code <= err_code_nxt;

      if (accept) begin
        idle_cnt <= '0;
      end else if ((state == S_HDR1) || (state == S_DATA) || (state == S_CHK)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (can_start && start) begin
        words_loaded <= '0;
        chk_acc      <= 8'h00;
        byte_idx     <= 2'd0;
        imem_addr    <= '0;
        idle_cnt     <= '0;
      end

      if (accept) begin
        case (state)
          S_HDR0: len_hi  <= in_data;
          S_HDR1: n_words <= n_hdr[AW:0];
          S_DATA: begin
            word_sr  <= {word_sr[15:0], in_data};
            chk_acc  <= chk_acc ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            // Fourth byte completes the word: write it on this same edge.
            if (last_byte_of_word) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[AW-1:0];
              imem_wdata   <= {word_sr, in_data};
              words_loaded <= words_loaded + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int AW    = 6;
  localparam int TO    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_clr;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   words_loaded;
  logic [2:0]    dbg_state;

  imem_boot_loader #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_clr(cpu_clr), .done(done), .err(err),
    .err_code(err_code), .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [AW+31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every memory write must match the next expected {addr, word}.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {imem_addr, imem_wdata}, 64'hdead);
      end else begin
        check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) cycle();
    in_valid = 1'b1;
    in_data  = b;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_clr"}, cpu_clr, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_words"}, words_loaded, 0);
  endtask

  // ---------------- reference model + frame runner ----------------
  // fr: bytes to send, gp[i]: idle cycles before byte i.
  logic [7:0] fr[$];
  int         gp[$];

  task automatic run_frame(input string tag);
    int n, tot, k, stop, nw, code;
    logic [7:0] x;
    n   = int'({fr[0], fr[1]});
    tot = (n > DEPTH) ? 2 : 4 * n + 3;
    k   = -1;
    for (int i = 1; i < fr.size() && i < tot; i++)
      if (k < 0 && gp[i] >= TO) k = i;
    if (k >= 0) begin
      code = 3; stop = k;
    end else if (fr.size() < tot) begin
      code = 3; stop = fr.size();
    end else if (n > DEPTH) begin
      code = 1; stop = 2;
    end else begin
      stop = tot;
      x = 8'h00;
      for (int i = 2; i < tot - 1; i++) x ^= fr[i];
      code = (fr[tot-1] == x) ? 0 : 2;
    end
    if (code == 1) nw = 0;
    else begin
      nw = (stop - 2) / 4;
      if (nw < 0) nw = 0;
      if (nw > n) nw = n;
    end
    for (int w = 0; w < nw; w++) begin
      logic [AW-1:0] a;
      a = w[AW-1:0];
      exp_q.push_back({a, fr[2+4*w], fr[3+4*w], fr[4+4*w], fr[5+4*w]});
    end

    pulse_start();
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], gp[i]);
      if (i == 0) check({tag, "_cpu_clr_busy"}, cpu_clr, 1);
    end
    repeat (TO + 4) cycle();

    check({tag, "_done"}, done, (code == 0));
    check({tag, "_err"}, err, (code != 0));
    check({tag, "_err_code"}, err_code, code);
    check({tag, "_words"}, words_loaded, nw);
    check({tag, "_cpu_clr"}, cpu_clr, (code != 0));
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_spec_frame(input logic [7:0] chk, input int max_gap);
    logic [7:0] b[11];
    b = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07, 8'h03};
    b[10] = chk;
    fr.delete(); gp.delete();
    for (int i = 0; i < 11; i++) begin
      fr.push_back(b[i]);
      gp.push_back($urandom_range(0, max_gap));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset state while clr is held
    cycle();
    check_reset_outputs("reset");
    check("reset_state", dbg_state, 0);
    clr = 1'b0;
    cycle();

    // Spec frame, no gaps: writes 20080005 / 20090007, done
    load_spec_frame(8'h03, 0);
    run_frame("spec_ok");

    // Bad checksum
    load_spec_frame(8'h04, 0);
    run_frame("bad_chk");

    // Length one past depth
    fr = '{8'h00, 8'h41}; gp = '{0, 0};
    run_frame("too_long");

    // Length exactly depth is legal (header only sent, stalls -> timeout)
    fr = '{8'h00, 8'h40, 8'h12}; gp = '{0, 0, 0};
    run_frame("depth_trunc");

    // Gapped below the timeout
    load_spec_frame(8'h03, TO - 1);
    run_frame("spec_gapped");

    // Gap of TO-1 before byte 6 survives, gap of TO times out after word 0
    load_spec_frame(8'h03, 3); gp[6] = TO - 1;
    run_frame("gap_max");
    load_spec_frame(8'h03, 3); gp[6] = TO;
    run_frame("gap_timeout");

    // Long first-byte wait in HDR0 never times out
    load_spec_frame(8'h03, 2); gp[0] = 3 * TO;
    run_frame("hdr0_wait");

    // Stall in DATA
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00}; gp = '{0, 0, 0, 0, 0};
    run_frame("data_stall");

    // clr in the middle of DATA, after one word was written
    load_spec_frame(8'h03, 0);
    exp_q.push_back({6'd0, 32'h20080005});
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(fr[i], 0);
    #3 clr = 1'b1;
    #1 check_reset_outputs("clr_mid");
    check("clr_mid_writes_left", exp_q.size(), 0);
    cycle();
    clr = 1'b0;
    cycle();

    // Empty image
    fr = '{8'h00, 8'h00, 8'h00}; gp = '{1, 1, 1};
    run_frame("empty");

    // start together with clr: clr wins, no frame begins
    start = 1'b1; clr = 1'b1;
    cycle();
    start = 1'b0; clr = 1'b0;
    cycle();
    check("start_clr_ready", in_ready, 0);
    check("start_clr_done", done, 0);

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      int sel, n, tot;
      logic [7:0] x;
      sel = $urandom_range(0, 9);
      if (sel == 0)      n = DEPTH;
      else if (sel == 1) n = DEPTH + 1 + $urandom_range(0, 300);
      else               n = $urandom_range(0, 6);
      fr.delete(); gp.delete();
      fr.push_back(n[15:8]);
      fr.push_back(n[7:0]);
      if (n <= DEPTH) begin
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          x ^= b;
          fr.push_back(b);
        end
        if ($urandom_range(0, 4) == 0) x ^= 8'(1 << $urandom_range(0, 7));
        fr.push_back(x);
        tot = fr.size();
        if ($urandom_range(0, 7) == 0) begin
          int keep;
          keep = $urandom_range(2, tot - 1);
          while (fr.size() > keep) void'(fr.pop_back());
        end
      end
      for (int i = 0; i < fr.size(); i++) begin
        if ($urandom_range(0, 199) == 0) gp.push_back(TO + $urandom_range(0, 3));
        else                             gp.push_back($urandom_range(0, TO - 1));
      end
      run_frame("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
